// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock/tick divider with boundary-aligned reconfiguration
// Active D/H change only on a period wrap (or at once while disabled), so clk_out never emits a runt pulse.
module clk_div_prog #(
   parameter int SYS_FREQ = 100_000_000,
   parameter int CNT_W    = 27,
   parameter int F0       = 1,
   parameter int F1       = 2,
   parameter int F2       = 5,
   parameter int F3       = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [2:0]       cfg_sel,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_high,
   output logic             clk_out,
   output logic             tick
);

   localparam longint DIV0_L  = longint'(SYS_FREQ / F0);
   localparam longint DIV1_L  = longint'(SYS_FREQ / F1);
   localparam longint DIV2_L  = longint'(SYS_FREQ / F2);
   localparam longint DIV3_L  = longint'(SYS_FREQ / F3);
   localparam longint MAX_DIV = (longint'(1) << CNT_W) - 1;

   if (DIV0_L > MAX_DIV || DIV1_L > MAX_DIV || DIV2_L > MAX_DIV || DIV3_L > MAX_DIV) begin : g_div_check
      $error("clk_div_prog: a preset divisor does not fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] DIV0 = DIV0_L[CNT_W-1:0];
   localparam logic [CNT_W-1:0] DIV1 = DIV1_L[CNT_W-1:0];
   localparam logic [CNT_W-1:0] DIV2 = DIV2_L[CNT_W-1:0];
   localparam logic [CNT_W-1:0] DIV3 = DIV3_L[CNT_W-1:0];
   localparam logic [CNT_W-1:0] HIGH0 = DIV0 >> 1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] act_d, act_h;
   logic [CNT_W-1:0] sh_d, sh_h;
   logic [CNT_W-1:0] cust_d, new_d, new_h;
   logic             pending;
   logic             wrap;

   assign cfg_ready = ~pending;
   assign wrap      = (cnt == act_d - CNT_W'(1));

   // Period/high time the request would install, computed from the live cfg_* inputs.
   always_comb begin
      cust_d = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
      new_d  = cust_d;
      new_h  = cfg_high;
      if (!cfg_sel[2]) begin
         case (cfg_sel[1:0])
            2'd0: new_d = DIV0;
            2'd1: new_d = DIV1;
            2'd2: new_d = DIV2;
            2'd3: new_d = DIV3;
         endcase
         new_h = new_d >> 1;
      end else if (cfg_high == '0) begin
         new_h = cust_d >> 1;
      end else if (cfg_high >= cust_d) begin
         new_h = cust_d - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         pending <= 1'b0;
         act_d   <= DIV0;
         act_h   <= HIGH0;
         sh_d    <= DIV0;
         sh_h    <= HIGH0;
      end else begin
         if (en) cnt <= wrap ? '0 : cnt + CNT_W'(1);
         else    cnt <= '0;
         clk_out <= en & (cnt < act_h);
         tick    <= en & (cnt == '0);
         // Accept is blocked while pending, so apply and accept never collide.
         if (pending && (wrap || !en)) begin
            act_d   <= sh_d;
            act_h   <= sh_h;
            pending <= 1'b0;
         end else if (cfg_valid && !pending) begin
            sh_d    <= new_d;
            sh_h    <= new_h;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog
// Simulated at SYS_FREQ=100, CNT_W=8: presets are D=100/50/20/10.
module tb_clk_div_prog;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst, en, cfg_valid;
   logic             cfg_ready;
   logic [2:0]       cfg_sel;
   logic [CNT_W-1:0] cfg_div, cfg_high;
   logic             clk_out, tick;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   clk_div_prog #(
      .SYS_FREQ(100), .CNT_W(CNT_W), .F0(1), .F1(2), .F2(5), .F3(10)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_high(cfg_high),
      .clk_out(clk_out), .tick(tick)
   );

   task automatic send_cfg(input logic [2:0] sel, input logic [CNT_W-1:0] div,
                           input logic [CNT_W-1:0] high, output bit ok);
      int guard = 0;
      cfg_sel = sel; cfg_div = div; cfg_high = high; cfg_valid = 1'b1; ok = 1'b0;
      while (guard < 400) begin
         if (cfg_ready) begin
            @(negedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         guard++;
      end
      cfg_valid = 1'b0;
   endtask

   task automatic wait_ready(output bit ok);
      int guard = 0;
      while (!cfg_ready && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      ok = cfg_ready;
   endtask

   // Measures one clk_out period starting at the next (or current) tick sample.
   task automatic measure(output int hi, output int lo, output int extra, output bit ok);
      int guard = 0;
      hi = 0; lo = 0; extra = 0; ok = 1'b1;
      while (!tick && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (!tick) begin
         ok = 1'b0;
         return;
      end
      hi = 1;
      @(negedge clk);
      while (clk_out && guard < 400) begin
         if (tick) extra++;
         hi++;
         @(negedge clk);
         guard++;
      end
      while (!clk_out && guard < 400) begin
         if (tick) extra++;
         lo++;
         @(negedge clk);
         guard++;
      end
      if (guard >= 400) ok = 1'b0;
   endtask

   task automatic test_reset;
      int hi, lo, ex;
      bit ok;
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_sel = '0; cfg_div = '0; cfg_high = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (clk_out !== 1'b0 || tick !== 1'b0 || cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: clk_out=%b tick=%b cfg_ready=%b, want 0 0 1", clk_out, tick, cfg_ready);
      end
      rst = 1'b0; en = 1'b1;
      @(negedge clk);
      n_checks++;
      if (clk_out !== 1'b1 || tick !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_rise: clk_out=%b tick=%b, want 1 1", clk_out, tick);
      end
      for (int p = 0; p < 2; p++) begin
         measure(hi, lo, ex, ok);
         n_checks++;
         if (!ok || hi !== 50 || lo !== 50 || ex !== 0 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL preset0_period%0d: hi=%0d lo=%0d extra=%0d tick_at_rise=%b ok=%0d, want 50 50 0 1 1",
                     p, hi, lo, ex, tick, ok);
         end
      end
   endtask

   task automatic test_custom;
      int hi, lo, ex;
      bit ok, okr;
      send_cfg(3'd4, 8'd7, 8'd0, ok);
      n_checks++;
      if (!ok || cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL custom7_accept: accepted=%0d cfg_ready=%b, want 1 0", ok, cfg_ready);
      end
      wait_ready(okr);
      for (int p = 0; p < 2; p++) begin
         measure(hi, lo, ex, ok);
         n_checks++;
         if (!okr || !ok || hi !== 3 || lo !== 4 || ex !== 0) begin
            n_fail++;
            $display("FAIL custom7_period%0d: hi=%0d lo=%0d extra=%0d ok=%0d/%0d, want 3 4 0 1/1",
                     p, hi, lo, ex, okr, ok);
         end
      end
   endtask

   task automatic test_preset_boundary;
      int hi, lo, ex, n, hi_old, ready_viol;
      bit ok, okr;
      send_cfg(3'd0, 8'd0, 8'd0, ok);
      wait_ready(okr);
      measure(hi, lo, ex, ok);
      while (!tick && hi < 400) begin
         @(negedge clk);
         hi++;
      end
      n = 0; hi_old = 1; ready_viol = 0;
      for (int j = 1; j <= 200; j++) begin
         @(negedge clk);
         if (j == 9) begin
            n_checks++;
            if (cfg_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL boundary_ready_before: cfg_ready=%b, want 1", cfg_ready);
            end
            cfg_sel = 3'd3; cfg_valid = 1'b1;
         end
         if (j == 10) begin
            cfg_valid = 1'b0;
            n_checks++;
            if (cfg_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL boundary_accept_cnt10: cfg_ready=%b, want 0", cfg_ready);
            end
         end
         if (j == 99) begin
            n_checks++;
            if (cfg_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL boundary_ready_after_wrap: cfg_ready=%b, want 1", cfg_ready);
            end
         end
         if (tick) begin
            n = j;
            break;
         end
         if (clk_out) hi_old++;
         if (j >= 10 && j <= 98 && cfg_ready) ready_viol++;
      end
      n_checks++;
      if (n !== 100 || hi_old !== 50 || ready_viol !== 0) begin
         n_fail++;
         $display("FAIL boundary_old_period: len=%0d high=%0d ready_early=%0d, want 100 50 0", n, hi_old, ready_viol);
      end
      for (int p = 0; p < 2; p++) begin
         measure(hi, lo, ex, ok);
         n_checks++;
         if (!ok || !okr || hi !== 5 || lo !== 5 || ex !== 0) begin
            n_fail++;
            $display("FAIL preset3_period%0d: hi=%0d lo=%0d extra=%0d ok=%0d, want 5 5 0 1", p, hi, lo, ex, ok);
         end
      end
   endtask

   task automatic test_custom_edges;
      int hi, lo, ex;
      bit ok, okr;
      send_cfg(3'd4, 8'd1, 8'd0, ok);
      wait_ready(okr);
      for (int p = 0; p < 2; p++) begin
         measure(hi, lo, ex, ok);
         n_checks++;
         if (!ok || !okr || hi !== 1 || lo !== 1 || ex !== 0) begin
            n_fail++;
            $display("FAIL div1_clamp_period%0d: hi=%0d lo=%0d extra=%0d ok=%0d, want 1 1 0 1", p, hi, lo, ex, ok);
         end
      end
      send_cfg(3'd5, 8'd5, 8'd9, ok);
      wait_ready(okr);
      for (int p = 0; p < 2; p++) begin
         measure(hi, lo, ex, ok);
         n_checks++;
         if (!ok || !okr || hi !== 4 || lo !== 1 || ex !== 0) begin
            n_fail++;
            $display("FAIL high_clamp_period%0d: hi=%0d lo=%0d extra=%0d ok=%0d, want 4 1 0 1", p, hi, lo, ex, ok);
         end
      end
   endtask

   task automatic test_back_to_back;
      int hi, lo, ex, busy;
      bit ok;
      send_cfg(3'd4, 8'd7, 8'd0, ok);
      cfg_sel = 3'd2; cfg_div = 8'd0; cfg_high = 8'd0; cfg_valid = 1'b1;
      busy = 0;
      while (!cfg_ready && busy < 400) begin
         @(negedge clk);
         busy++;
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      n_checks++;
      if (!ok || busy < 1 || busy >= 400 || cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second_accept: first_ok=%0d busy=%0d cfg_ready=%b, want 1 1..399 0", ok, busy, cfg_ready);
      end
      measure(hi, lo, ex, ok);
      n_checks++;
      if (!ok || hi !== 3 || lo !== 4 || ex !== 0) begin
         n_fail++;
         $display("FAIL b2b_first_cfg: hi=%0d lo=%0d extra=%0d ok=%0d, want 3 4 0 1", hi, lo, ex, ok);
      end
      measure(hi, lo, ex, ok);
      n_checks++;
      if (!ok || hi !== 10 || lo !== 10 || ex !== 0) begin
         n_fail++;
         $display("FAIL b2b_second_cfg: hi=%0d lo=%0d extra=%0d ok=%0d, want 10 10 0 1", hi, lo, ex, ok);
      end
   endtask

   task automatic test_disable;
      int hi, lo, ex;
      bit ok;
      en = 1'b0;
      @(negedge clk);
      n_checks++;
      if (clk_out !== 1'b0 || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL disable_outputs: clk_out=%b tick=%b, want 0 0", clk_out, tick);
      end
      send_cfg(3'd1, 8'd0, 8'd0, ok);
      n_checks++;
      if (!ok || cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL disable_accept: accepted=%0d cfg_ready=%b, want 1 0", ok, cfg_ready);
      end
      @(negedge clk);
      n_checks++;
      if (cfg_ready !== 1'b1 || clk_out !== 1'b0) begin
         n_fail++;
         $display("FAIL disable_apply_next: cfg_ready=%b clk_out=%b, want 1 0", cfg_ready, clk_out);
      end
      en = 1'b1;
      @(negedge clk);
      n_checks++;
      if (clk_out !== 1'b1 || tick !== 1'b1) begin
         n_fail++;
         $display("FAIL reenable_first_rise: clk_out=%b tick=%b, want 1 1", clk_out, tick);
      end
      measure(hi, lo, ex, ok);
      n_checks++;
      if (!ok || hi !== 25 || lo !== 25 || ex !== 0) begin
         n_fail++;
         $display("FAIL preset1_period: hi=%0d lo=%0d extra=%0d ok=%0d, want 25 25 0 1", hi, lo, ex, ok);
      end
   endtask

   task automatic test_reset_mid;
      int hi, lo, ex, guard;
      bit ok, okr;
      send_cfg(3'd0, 8'd0, 8'd0, ok);
      wait_ready(okr);
      guard = 0;
      while (!tick && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      for (int j = 1; j <= 39; j++) begin
         @(negedge clk);
         if (j == 5) begin
            cfg_sel = 3'd4; cfg_div = 8'd7; cfg_high = 8'd0; cfg_valid = 1'b1;
         end
         if (j == 6) cfg_valid = 1'b0;
      end
      n_checks++;
      if (!okr || guard >= 400 || clk_out !== 1'b1 || cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_setup: clk_out=%b cfg_ready=%b, want 1 0", clk_out, cfg_ready);
      end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (clk_out !== 1'b0 || tick !== 1'b0 || cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_async: clk_out=%b tick=%b cfg_ready=%b, want 0 0 1", clk_out, tick, cfg_ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (clk_out !== 1'b1 || tick !== 1'b1 || cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_release_rise: clk_out=%b tick=%b cfg_ready=%b, want 1 1 1", clk_out, tick, cfg_ready);
      end
      for (int p = 0; p < 2; p++) begin
         measure(hi, lo, ex, ok);
         n_checks++;
         if (!ok || hi !== 50 || lo !== 50 || ex !== 0) begin
            n_fail++;
            $display("FAIL rst_preset0_period%0d: hi=%0d lo=%0d extra=%0d ok=%0d, want 50 50 0 1", p, hi, lo, ex, ok);
         end
      end
   endtask

   initial begin
      test_reset;
      test_custom;
      test_preset_boundary;
      test_custom_edges;
      test_back_to_back;
      test_disable;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
